load_store_unit: RTL and testbench

- Initiator side of the data-memory port. Accepts one load/store request at a time from the pipeline MEM stage over a valid/ready handshake.
- Drives the memory strobes, waits on a memory-ready signal, and returns the response: extended load data, or completion of a store.
- Misaligned halfword/word accesses are split into sequential byte accesses and reassembled, so memory only ever sees naturally aligned transfers. Out-of-range and illegal-size requests are reported as errors without touching memory.

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/lsu_load_extend.sv | 24 ++
 rtl/load_store_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// the byte count of an access size.
package load_store_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SPLIT  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    // Bytes touched by an access; the illegal code maps to 1 so range math stays sane.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SZ_HALF: size_nbytes = 3'd2;
            SZ_WORD: size_nbytes = 3'd4;
            default: size_nbytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load extension, same rules as the data memory.
//   i_raw      : right-aligned raw load data
//   i_size     : access size code
//   i_sign_ext : 1 = sign-extend byte/halfword, 0 = zero-extend
//   o_data_c   : extended 32-bit result
module lsu_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    output logic [31:0] o_data_c
);

    always_comb begin
        o_data_c = i_raw;
        case (i_size)
            SZ_BYTE: o_data_c = {{24{i_sign_ext & i_raw[7]}}, i_raw[7:0]};
            SZ_HALF: o_data_c = {{16{i_sign_ext & i_raw[15]}}, i_raw[15:0]};
            default: o_data_c = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, drives aligned
// memory beats (splitting misaligned accesses into bytes when enabled) and
// returns a one-cycle response.
//   clock, reset           : rising-edge clock, async active-high reset
//   req_*                  : pipeline request (valid/ready handshake)
//   resp_*                 : completion pulse, load data, error flag
//   mem_*                  : memory strobes/address/data, mem_ready handshake
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES        = 1024,
    parameter int unsigned SPLIT_MISALIGNED = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign_ext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [1:0]  mem_byte_size,
    output logic        mem_sign_ext,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  r_state, w_state_nxt;
    logic [1:0]  r_k, w_k_nxt;
    logic        r_write, w_write_nxt;
    logic [1:0]  r_size, w_size_nxt;
    logic        r_sign, w_sign_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_asm, w_asm_nxt;

    logic        r_req_ready, w_req_ready_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
    logic        r_resp_error, w_resp_error_nxt;
    logic [31:0] r_mem_address, w_mem_address_nxt;
    logic [31:0] r_mem_write_data, w_mem_write_data_nxt;
    logic        r_mem_memwrite, w_mem_memwrite_nxt;
    logic        r_mem_memread, w_mem_memread_nxt;
    logic [1:0]  r_mem_byte_size, w_mem_byte_size_nxt;
    logic        r_mem_sign_ext, w_mem_sign_ext_nxt;

    logic [32:0] w_end;
    logic        w_oor;
    logic        w_misal;
    logic        w_req_err;
    logic        w_last;
    logic [1:0]  w_k_inc;
    logic [7:0]  w_beat_byte;
    logic [31:0] w_asm_beat;
    logic [31:0] w_ext_data;

    // Request classification; end address in 33 bits so wrap-around is out of range.
    assign w_end     = {1'b0, req_addr} + 33'(size_nbytes(req_size)) - 33'd1;
    assign w_oor     = (w_end >= 33'(MEM_BYTES));
    assign w_misal   = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_req_err = (req_size == SZ_ILL) || w_oor ||
                       (w_misal && (SPLIT_MISALIGNED == 0));

    // Split-beat bookkeeping.
    assign w_last      = ({1'b0, r_k} == (size_nbytes(r_size) - 3'd1));
    assign w_k_inc     = r_k + 2'd1;
    assign w_beat_byte = 8'(r_wdata >> {w_k_inc, 3'b000});

    // Drop the returned byte into its slot of the assembly register.
    always_comb begin
        w_asm_beat = r_asm;
        w_asm_beat[{r_k, 3'b000} +: 8] = mem_read_data[7:0];
    end

    lsu_load_extend u_load_extend (
        .i_raw      (w_asm_beat),
        .i_size     (r_size),
        .i_sign_ext (r_sign),
        .o_data_c   (w_ext_data)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt          = r_state;
        w_k_nxt              = r_k;
        w_write_nxt          = r_write;
        w_size_nxt           = r_size;
        w_sign_nxt           = r_sign;
        w_addr_nxt           = r_addr;
        w_wdata_nxt          = r_wdata;
        w_asm_nxt            = r_asm;
        w_resp_valid_nxt     = 1'b0;
        w_resp_rdata_nxt     = r_resp_rdata;
        w_resp_error_nxt     = r_resp_error;
        w_mem_address_nxt    = r_mem_address;
        w_mem_write_data_nxt = r_mem_write_data;
        w_mem_memwrite_nxt   = r_mem_memwrite;
        w_mem_memread_nxt    = r_mem_memread;
        w_mem_byte_size_nxt  = r_mem_byte_size;
        w_mem_sign_ext_nxt   = r_mem_sign_ext;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_write_nxt = req_write;
                    w_size_nxt  = req_size;
                    w_sign_nxt  = req_sign_ext;
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                    w_asm_nxt   = '0;
                    w_k_nxt     = '0;
                    if (w_req_err) begin
                        w_state_nxt      = ST_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_rdata_nxt = '0;
                        w_resp_error_nxt = 1'b1;
                    end else if (!w_misal) begin
                        w_state_nxt          = ST_ACCESS;
                        w_mem_address_nxt    = req_addr;
                        w_mem_write_data_nxt = req_wdata;
                        w_mem_memwrite_nxt   = req_write;
                        w_mem_memread_nxt    = !req_write;
                        w_mem_byte_size_nxt  = req_size;
                        w_mem_sign_ext_nxt   = req_sign_ext;
                    end else begin
                        w_state_nxt          = ST_SPLIT;
                        w_mem_address_nxt    = req_addr;
                        w_mem_write_data_nxt = {24'b0, req_wdata[7:0]};
                        w_mem_memwrite_nxt   = req_write;
                        w_mem_memread_nxt    = !req_write;
                        w_mem_byte_size_nxt  = SZ_BYTE;
                        w_mem_sign_ext_nxt   = 1'b0;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_ready) begin
                    w_state_nxt          = ST_RESP;
                    w_resp_valid_nxt     = 1'b1;
                    w_resp_rdata_nxt     = r_write ? 32'd0 : mem_read_data;
                    w_resp_error_nxt     = 1'b0;
                    w_mem_address_nxt    = '0;
                    w_mem_write_data_nxt = '0;
                    w_mem_memwrite_nxt   = 1'b0;
                    w_mem_memread_nxt    = 1'b0;
                    w_mem_byte_size_nxt  = '0;
                    w_mem_sign_ext_nxt   = 1'b0;
                end
            end

            ST_SPLIT: begin
                if (mem_ready) begin
                    w_asm_nxt = w_asm_beat;
                    if (w_last) begin
                        w_state_nxt          = ST_RESP;
                        w_resp_valid_nxt     = 1'b1;
                        w_resp_rdata_nxt     = r_write ? 32'd0 : w_ext_data;
                        w_resp_error_nxt     = 1'b0;
                        w_mem_address_nxt    = '0;
                        w_mem_write_data_nxt = '0;
                        w_mem_memwrite_nxt   = 1'b0;
                        w_mem_memread_nxt    = 1'b0;
                        w_mem_byte_size_nxt  = '0;
                        w_mem_sign_ext_nxt   = 1'b0;
                    end else begin
                        w_k_nxt              = w_k_inc;
                        w_mem_address_nxt    = r_addr + 32'(w_k_inc);
                        w_mem_write_data_nxt = {24'b0, w_beat_byte};
                    end
                end
            end

            ST_RESP: w_state_nxt = ST_IDLE;

            default: w_state_nxt = ST_IDLE;
        endcase

        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_k              <= '0;
            r_write          <= 1'b0;
            r_size           <= '0;
            r_sign           <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_asm            <= '0;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= '0;
            r_resp_error     <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_memwrite   <= 1'b0;
            r_mem_memread    <= 1'b0;
            r_mem_byte_size  <= '0;
            r_mem_sign_ext   <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_k              <= w_k_nxt;
            r_write          <= w_write_nxt;
            r_size           <= w_size_nxt;
            r_sign           <= w_sign_nxt;
            r_addr           <= w_addr_nxt;
            r_wdata          <= w_wdata_nxt;
            r_asm            <= w_asm_nxt;
            r_req_ready      <= w_req_ready_nxt;
            r_resp_valid     <= w_resp_valid_nxt;
            r_resp_rdata     <= w_resp_rdata_nxt;
            r_resp_error     <= w_resp_error_nxt;
            r_mem_address    <= w_mem_address_nxt;
            r_mem_write_data <= w_mem_write_data_nxt;
            r_mem_memwrite   <= w_mem_memwrite_nxt;
            r_mem_memread    <= w_mem_memread_nxt;
            r_mem_byte_size  <= w_mem_byte_size_nxt;
            r_mem_sign_ext   <= w_mem_sign_ext_nxt;
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign resp_error     = r_resp_error;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign mem_memwrite   = r_mem_memwrite;
    assign mem_memread    = r_mem_memread;
    assign mem_byte_size  = r_mem_byte_size;
    assign mem_sign_ext   = r_mem_sign_ext;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid, req2_valid;
    logic        req_ready, req2_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sign_ext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp2_valid;
    logic [31:0] resp_rdata, resp2_rdata;
    logic        resp_error, resp2_error;
    logic [31:0] mem_address, mem2_address;
    logic [31:0] mem_write_data, mem2_write_data;
    logic        mem_memwrite, mem2_memwrite;
    logic        mem_memread, mem2_memread;
    logic [1:0]  mem_byte_size, mem2_byte_size;
    logic        mem_sign_ext, mem2_sign_ext;
    logic        mem_ready;
    logic [31:0] mem_read_data;
    logic        mready;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        wr;
    } beat_t;

    exp_t  sb[$];
    beat_t beats[$];
    logic [7:0] mem [0:1023];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int strobe_viol = 0;
    int strobe2_cnt = 0;

    load_store_unit #(.MEM_BYTES(1024), .SPLIT_MISALIGNED(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_byte_size(mem_byte_size), .mem_sign_ext(mem_sign_ext),
        .mem_ready(mem_ready), .mem_read_data(mem_read_data)
    );

    load_store_unit #(.MEM_BYTES(1024), .SPLIT_MISALIGNED(0)) dut_nosplit (
        .clock(clock), .reset(reset),
        .req_valid(req2_valid), .req_ready(req2_ready), .req_write(req_write),
        .req_size(req_size), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp2_valid), .resp_rdata(resp2_rdata), .resp_error(resp2_error),
        .mem_address(mem2_address), .mem_write_data(mem2_write_data),
        .mem_memwrite(mem2_memwrite), .mem_memread(mem2_memread),
        .mem_byte_size(mem2_byte_size), .mem_sign_ext(mem2_sign_ext),
        .mem_ready(1'b1), .mem_read_data(32'd0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign mem_ready = mready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory read model: little-endian, extended per size/sign.
    always_comb begin
        logic [9:0]  a;
        logic [31:0] raw;
        a   = mem_address[9:0];
        raw = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
        case (mem_byte_size)
            SZ_BYTE: mem_read_data = mem_sign_ext ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
            SZ_HALF: mem_read_data = mem_sign_ext ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
            default: mem_read_data = raw;
        endcase
    end

    // Memory write model and beat log.
    always @(posedge clock) begin
        if (!reset && mready && (mem_memread || mem_memwrite)) begin
            beats.push_back('{mem_address, mem_write_data, mem_byte_size, mem_memwrite});
            if (mem_memwrite) begin
                mem[mem_address[9:0]] <= mem_write_data[7:0];
                if (mem_byte_size != SZ_BYTE) mem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
                if (mem_byte_size == SZ_WORD) begin
                    mem[mem_address[9:0] + 10'd2] <= mem_write_data[23:16];
                    mem[mem_address[9:0] + 10'd3] <= mem_write_data[31:24];
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every response pulse.
    always @(negedge clock) begin
        if (mem_memread && mem_memwrite) strobe_viol++;
        if (mem2_memread || mem2_memwrite) strobe2_cnt++;
        if (resp_valid) begin
            chk("ready_in_resp", 32'(req_ready), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
                chk({e.tag, "_err"}, 32'(resp_error), 32'(e.err));
                chk({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input string tag,
                         input logic [31:0] erd, input logic eerr, input int elat,
                         input bit push);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        req_write = w; req_size = sz; req_sign_ext = sx; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        if (push) sb.push_back('{tag, erd, eerr, elat, cyc});
        @(posedge clock);
        #1;
        // Scramble request inputs: the unit must have latched them already.
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = $urandom;
        req_sign_ext = ~sx;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input string tag,
                       input logic [31:0] erd, input logic eerr, input int elat);
        issue(w, sz, sx, a, wd, tag, erd, eerr, elat, 1'b1);
        wait_resp();
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] sz, input logic wr);
        beat_t b;
        b = '{32'hXXXX_XXXX, 32'hXXXX_XXXX, 2'bxx, 1'bx};
        if (idx < beats.size()) b = beats[idx];
        chk({tag, "_addr"}, b.addr, addr);
        chk({tag, "_wdata"}, b.wdata, wd);
        chk({tag, "_size"}, 32'(b.size), 32'(sz));
        chk({tag, "_wr"}, 32'(b.wr), 32'(wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        logic [7:0] sw_bytes [4];
        bit found;
        sw_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        reset = 1'b1; mready = 1'b1;
        req_valid = 1'b0; req2_valid = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_sign_ext = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_error", 32'(resp_error), 32'd0);
        chk("rst_strobes", 32'({mem_memread, mem_memwrite}), 32'd0);
        reset = 1'b0;

        // Aligned store then load
        n0 = beats.size();
        txn(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw_al", 32'd0, 1'b0, 2);
        chk("sw_al_nbeats", 32'(beats.size() - n0), 32'd1);
        chk_beat("sw_al_b0", n0, 32'h10, 32'hDEAD_BEEF, SZ_WORD, 1'b1);
        n0 = beats.size();
        txn(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, "lw_al", 32'hDEAD_BEEF, 1'b0, 2);
        chk("lw_al_nbeats", 32'(beats.size() - n0), 32'd1);
        @(negedge clock);
        chk("hold_rdata", resp_rdata, 32'hDEAD_BEEF);

        // Sub-word loads
        txn(1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, "lb", 32'hFFFF_FFEF, 1'b0, 2);
        txn(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, "lbu", 32'h0000_00EF, 1'b0, 2);
        txn(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, "lh", 32'hFFFF_DEAD, 1'b0, 2);
        txn(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, "lhu", 32'h0000_DEAD, 1'b0, 2);

        // Misaligned word store/load split into bytes
        n0 = beats.size();
        txn(1'b1, SZ_WORD, 1'b0, 32'h21, 32'h1122_3344, "sw_split", 32'd0, 1'b0, 5);
        chk("sw_split_nbeats", 32'(beats.size() - n0), 32'd4);
        for (int k = 0; k < 4; k++)
            chk_beat($sformatf("sw_split_b%0d", k), n0 + k, 32'h21 + 32'(k),
                     {24'b0, sw_bytes[k]}, SZ_BYTE, 1'b1);
        n0 = beats.size();
        txn(1'b0, SZ_WORD, 1'b0, 32'h21, 32'h0, "lw_split", 32'h1122_3344, 1'b0, 5);
        chk("lw_split_nbeats", 32'(beats.size() - n0), 32'd4);

        // Misaligned halfword with negative value
        txn(1'b1, SZ_HALF, 1'b0, 32'h31, 32'h0000_80F0, "sh_split", 32'd0, 1'b0, 3);
        txn(1'b0, SZ_HALF, 1'b1, 32'h31, 32'h0, "lh_split", 32'hFFFF_80F0, 1'b0, 3);
        txn(1'b0, SZ_HALF, 1'b0, 32'h31, 32'h0, "lhu_split", 32'h0000_80F0, 1'b0, 3);

        // Top of memory is still in range
        txn(1'b1, SZ_WORD, 1'b0, 32'h3FC, 32'hCAFE_F00D, "sw_top", 32'd0, 1'b0, 2);
        txn(1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, "lw_top", 32'hCAFE_F00D, 1'b0, 2);

        // Memory stall for 3 cycles during ACCESS
        mready = 1'b0;
        n0 = beats.size();
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, "lw_stall", 32'hDEAD_BEEF, 1'b0, 5, 1'b1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            chk("stall_addr", mem_address, 32'h10);
            chk("stall_rd", 32'({mem_memread, mem_memwrite}), 32'd2);
            chk("stall_size", 32'(mem_byte_size), 32'(SZ_WORD));
        end
        @(negedge clock);
        mready = 1'b1;
        wait_resp();
        chk("lw_stall_nbeats", 32'(beats.size() - n0), 32'd1);

        // Errors: no memory traffic
        n0 = beats.size();
        txn(1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, "err_size", 32'd0, 1'b1, 1);
        txn(1'b0, SZ_WORD, 1'b0, 32'h3FE, 32'h0, "err_lw3fe", 32'd0, 1'b1, 1);
        txn(1'b0, SZ_HALF, 1'b0, 32'h3FF, 32'h0, "err_lh3ff", 32'd0, 1'b1, 1);
        txn(1'b1, SZ_WORD, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, "err_wrap", 32'd0, 1'b1, 1);
        chk("err_nbeats", 32'(beats.size() - n0), 32'd0);

        // Split disabled: misaligned word is an error
        @(negedge clock);
        req_write = 1'b0; req_size = SZ_WORD; req_sign_ext = 1'b0; req_addr = 32'h2;
        req2_valid = 1'b1;
        @(posedge clock);
        #1 req2_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clock);
            if (resp2_valid) begin
                found = 1'b1;
                chk("nosplit_err", 32'(resp2_error), 32'd1);
                chk("nosplit_rdata", resp2_rdata, 32'd0);
            end
        end
        chk("nosplit_resp_seen", 32'(found), 32'd1);
        @(negedge clock);
        chk("nosplit_pulse", 32'(resp2_valid), 32'd0);
        chk("nosplit_strobes", 32'(strobe2_cnt), 32'd0);

        // Reset in the middle of split beat 2
        issue(1'b0, SZ_WORD, 1'b0, 32'h21, 32'h0, "rst_split", 32'd0, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clock);
        chk("rst_split_beat2", mem_address, 32'h23);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_strobe", 32'({mem_memread, mem_memwrite}), 32'd0);
        chk("rst_async_addr", mem_address, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        txn(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, "lw_after_rst", 32'hDEAD_BEEF, 1'b0, 2);

        chk("strobe_exclusive", 32'(strobe_viol), 32'd0);
        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
